// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-read-port register file with EX/MEM/WB forwarding and busy scoreboard
// Optional: REGFILE_RST_CLEAR_EN makes reset also zero every array entry.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_we,
  input  logic [ADDR_W-1:0]          ex_waddr,
  input  logic [DATA_W-1:0]          ex_wdata,
  input  logic                       ex_is_load,
  input  logic                       mem_we,
  input  logic [ADDR_W-1:0]          mem_waddr,
  input  logic [DATA_W-1:0]          mem_wdata,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       stall_req,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [NUM_RD-1:0] port_stall;
  logic              sb_hit;
  logic              cnt_inc;
  logic              cnt_dec;

  always_ff @(posedge clk) begin
`ifdef REGFILE_RST_CLEAR_EN
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
`else
    if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
`endif
  end

  assign sb_hit = sb_set && (sb_addr != '0);

  // Set is applied after clear so a newly issued op on the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[waddr] = 1'b0;
    if (sb_hit) busy_nxt[sb_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign cnt_inc = sb_hit && !busy[sb_addr];
  assign cnt_dec = we && busy[waddr] && !(sb_hit && sb_addr == waddr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;
      logic              live;
      logic              ex_hit;
      logic              mem_hit;
      logic              wb_hit;

      assign ra      = raddr[g*ADDR_W +: ADDR_W];
      assign live    = rst && re[g] && (ra != '0);
      assign ex_hit  = ex_we && (ex_waddr == ra);
      assign mem_hit = mem_we && (mem_waddr == ra);
      assign wb_hit  = we && (waddr == ra);

      always_comb begin
        rd_val = '0;
        if (live) begin
          if (ex_hit)       rd_val = ex_wdata;
          else if (mem_hit) rd_val = mem_wdata;
          else if (wb_hit)  rd_val = wdata;
          else              rd_val = mem[ra];
        end
      end

      assign rdata[g*DATA_W +: DATA_W] = rd_val;
      // A same-cycle WB write to a busy register satisfies the read via bypass.
      assign port_stall[g] = live && ((ex_hit && ex_is_load) || (busy[ra] && !wb_hit));
    end
  endgenerate

  assign stall_req = |port_stall;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed and random checks of regfile_mp_sb against a behavioural model
module tb_regfile_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  logic ex_we, ex_is_load, mem_we, we, sb_set;
  logic [AW-1:0] ex_waddr, mem_waddr, waddr, sb_addr;
  logic [DW-1:0] ex_wdata, mem_wdata, wdata;
  logic [NR-1:0] re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic stall_req;
  logic [AW:0] busy_cnt;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .re(re), .raddr(raddr), .rdata(rdata),
    .stall_req(stall_req), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [AW-1:0] port_addr(input int p);
    return raddr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] m_read(input int p);
    logic [AW-1:0] a = port_addr(p);
    if (!rst || !re[p] || a == 0) return '0;
    if (ex_we && ex_waddr == a) return ex_wdata;
    if (mem_we && mem_waddr == a) return mem_wdata;
    if (we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic m_stall();
    logic s = 1'b0;
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0] a = port_addr(p);
      if (rst && re[p] && a != 0) begin
        if (ex_we && ex_is_load && ex_waddr == a) s = 1'b1;
        if (m_busy[a] && !(we && waddr == a)) s = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic idle();
    rst = 1'b1; ex_we = 0; ex_is_load = 0; mem_we = 0; we = 0; sb_set = 0;
    ex_waddr = 0; mem_waddr = 0; waddr = 0; sb_addr = 0;
    ex_wdata = 0; mem_wdata = 0; wdata = 0; re = 0; raddr = 0;
  endtask

  task automatic check_all(input string tag);
    #1;
    for (int p = 0; p < NR; p++) chk({tag, "_rdata"}, 64'(rdata[p*DW +: DW]), 64'(m_read(p)));
    chk({tag, "_stall"}, 64'(stall_req), 64'(m_stall()));
  endtask

  // Apply this cycle's inputs to the model, cross the edge, compare the counter.
  task automatic tick();
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
`ifdef REGFILE_RST_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
`else
      if (we && waddr != 0) m_mem[waddr] = wdata;
`endif
    end else begin
      if (we && waddr != 0) m_mem[waddr] = wdata;
      if (we) m_busy[waddr] = 1'b0;
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("busy_cnt", 64'(busy_cnt), 64'(m_count()));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 'x;
      m_busy[i] = 1'b0;
    end
    idle();
    rst = 1'b0;
    re = '1;
    raddr = {5'd3, 5'd1};
    check_all("reset_out");
    tick();
    chk("reset_cnt", 64'(busy_cnt), 64'd0);
    idle();

    for (int i = 1; i < DEPTH; i++) begin
      we = 1; waddr = AW'(i); wdata = 32'h1000 + i;
      tick();
    end
    idle();

    // Forwarding priority
    ex_we = 1; ex_waddr = 1; ex_wdata = 32'h11;
    mem_we = 1; mem_waddr = 1; mem_wdata = 32'h22;
    we = 1; waddr = 1; wdata = 32'h33;
    re = 2'b01; raddr = {5'd0, 5'd1};
    check_all("prio_ex");  chk("prio_ex_k", 64'(rdata[31:0]), 64'h11);
    ex_we = 0;
    check_all("prio_mem"); chk("prio_mem_k", 64'(rdata[31:0]), 64'h22);
    mem_we = 0;
    check_all("prio_wb");  chk("prio_wb_k", 64'(rdata[31:0]), 64'h33);
    we = 0;
    check_all("prio_arr"); chk("prio_arr_k", 64'(rdata[31:0]), 64'h1001);
    idle();

    // r0 hardwired
    we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
    tick();
    idle();
    re = '1; raddr = {5'd0, 5'd0};
    check_all("r0_read"); chk("r0_read_k", 64'(rdata), 64'd0);
    sb_set = 1; sb_addr = 0;
    tick();
    chk("r0_sb_cnt", 64'(busy_cnt), 64'd0);
    idle();

    // Load-use
    ex_we = 1; ex_is_load = 1; ex_waddr = 5; ex_wdata = 32'h5555;
    re = 2'b10; raddr = {5'd5, 5'd0};
    check_all("ldu_hit"); chk("ldu_hit_k", 64'(stall_req), 64'd1);
    ex_is_load = 0;
    check_all("ldu_off"); chk("ldu_off_k", 64'(stall_req), 64'd0);
    chk("ldu_fwd_k", 64'(rdata[63:32]), 64'h5555);
    idle();

    // Scoreboard with WB bypass
    sb_set = 1; sb_addr = 7;
    tick();
    chk("sb_set_cnt", 64'(busy_cnt), 64'd1);
    idle();
    re = 2'b01; raddr = {5'd0, 5'd7};
    check_all("sb_busy"); chk("sb_busy_k", 64'(stall_req), 64'd1);
    we = 1; waddr = 7; wdata = 32'hABCD;
    check_all("sb_bypass"); chk("sb_bypass_k", 64'(stall_req), 64'd0);
    chk("sb_bypass_d", 64'(rdata[31:0]), 64'hABCD);
    tick();
    chk("sb_clr_cnt", 64'(busy_cnt), 64'd0);
    idle();

    // Set/clear race on the same register
    sb_set = 1; sb_addr = 9; we = 1; waddr = 9; wdata = 32'h9999;
    tick();
    chk("race_cnt", 64'(busy_cnt), 64'd1);
    idle();
    re = 2'b01; raddr = {5'd0, 5'd9};
    check_all("race_busy"); chk("race_stall_k", 64'(stall_req), 64'd1);
    chk("race_data_k", 64'(rdata[31:0]), 64'h9999);
    we = 1; waddr = 9; wdata = 32'h9999;
    tick();
    idle();

    // Reset mid-operation
    sb_set = 1; sb_addr = 3; tick();
    sb_addr = 4; tick();
    chk("rst_pre_cnt", 64'(busy_cnt), 64'd2);
    idle();
    rst = 0; re = '1; raddr = {5'd4, 5'd3};
    check_all("rst_mid"); chk("rst_mid_stall", 64'(stall_req), 64'd0);
    tick();
    chk("rst_cnt", 64'(busy_cnt), 64'd0);
    idle();
    re = 2'b01; raddr = {5'd0, 5'd3};
    check_all("rst_after");
    chk("rst_after_stall", 64'(stall_req), 64'd0);
`ifdef REGFILE_RST_CLEAR_EN
    chk("rst_r3_k", 64'(rdata[31:0]), 64'd0);
`else
    chk("rst_r3_k", 64'(rdata[31:0]), 64'h1003);
`endif
    idle();

    // Random traffic with clustered addresses to force collisions
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 59) != 0);
      ex_we      = 1'($urandom_range(0, 1));
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_waddr   = AW'($urandom_range(0, 7));
      ex_wdata   = $urandom;
      mem_we     = 1'($urandom_range(0, 1));
      mem_waddr  = AW'($urandom_range(0, 7));
      mem_wdata  = $urandom;
      we         = 1'($urandom_range(0, 1));
      waddr      = AW'($urandom_range(0, 7));
      wdata      = $urandom;
      sb_set     = ($urandom_range(0, 2) == 0);
      sb_addr    = AW'($urandom_range(0, 7));
      re         = NR'($urandom_range(0, 3));
      raddr      = {AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9))};
      check_all("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
